// File: rtl/ibex_fpu_issue_seq.sv
// rtl/ibex_fpu_issue_seq.sv - FPU issue/writeback sequencer: holds operands on dp_* for a per-class
// latency, routes the result to the FP or integer regfile and accumulates fflags.
module ibex_fpu_issue_seq #(
  parameter int unsigned LAT_SHORT   = 1,
  parameter int unsigned LAT_ADD     = 2,
  parameter int unsigned LAT_MUL     = 3,
  parameter int unsigned LAT_MAC     = 4,
  parameter int unsigned LAT_CVT     = 2,
  parameter int unsigned LAT_DIVSQRT = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  op_i,
  input  logic [2:0]  rm_i,
  input  logic [2:0]  frm_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rs3_i,
  input  logic [31:0] rs1_int_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic [4:0]  dp_op_o,
  output logic [2:0]  dp_rnd_o,
  output logic [31:0] dp_rs1_o,
  output logic [31:0] dp_rs2_o,
  output logic [31:0] dp_rs3_o,
  output logic [31:0] dp_rs1_int_o,
  input  logic [31:0] dp_result_i,
  input  logic [7:0]  dp_status_i,
  output logic        fp_we_o,
  output logic [4:0]  fp_waddr_o,
  output logic [31:0] fp_wdata_o,
  output logic        int_we_o,
  output logic [4:0]  int_waddr_o,
  output logic [31:0] int_wdata_o,
  output logic        illegal_rm_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i
);

  localparam logic [4:0] OP_NOP         = 5'd0;
  localparam logic [4:0] OP_ADD         = 5'd1;
  localparam logic [4:0] OP_SUB         = 5'd2;
  localparam logic [4:0] OP_MUL         = 5'd3;
  localparam logic [4:0] OP_DIV         = 5'd4;
  localparam logic [4:0] OP_SQRT        = 5'd5;
  localparam logic [4:0] OP_MADD        = 5'd6;
  localparam logic [4:0] OP_MSUB        = 5'd7;
  localparam logic [4:0] OP_NMADD       = 5'd8;
  localparam logic [4:0] OP_NMSUB       = 5'd9;
  localparam logic [4:0] OP_SGNJ        = 5'd10;
  localparam logic [4:0] OP_SGNJN       = 5'd11;
  localparam logic [4:0] OP_SGNJX       = 5'd12;
  localparam logic [4:0] OP_MIN         = 5'd13;
  localparam logic [4:0] OP_MAX         = 5'd14;
  localparam logic [4:0] OP_CMP_EQ      = 5'd15;
  localparam logic [4:0] OP_CMP_LT      = 5'd16;
  localparam logic [4:0] OP_CMP_LE      = 5'd17;
  localparam logic [4:0] OP_FCLASS      = 5'd18;
  localparam logic [4:0] OP_MOVE_F2I    = 5'd19;
  localparam logic [4:0] OP_MOVE_I2F    = 5'd20;
  localparam logic [4:0] OP_FLOAT2INT   = 5'd21;
  localparam logic [4:0] OP_FLOAT2INT_U = 5'd22;
  localparam logic [4:0] OP_INT2FLOAT   = 5'd23;
  localparam logic [4:0] OP_INT2FLOAT_U = 5'd24;

  localparam logic [7:0] L_SHORT   = 8'(LAT_SHORT);
  localparam logic [7:0] L_ADD     = 8'(LAT_ADD);
  localparam logic [7:0] L_MUL     = 8'(LAT_MUL);
  localparam logic [7:0] L_MAC     = 8'(LAT_MAC);
  localparam logic [7:0] L_CVT     = 8'(LAT_CVT);
  localparam logic [7:0] L_DIVSQRT = 8'(LAT_DIVSQRT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q;
  logic [4:0]  fflags_d;
  logic        illegal_d;
  logic [2:0]  rm_res;
  logic        rm_bad;
  logic        cnt_zero;
  logic        take;
  logic        accept;
  logic        wb;
  logic        dest_int;
  logic        dest_fp;
  logic        flag_op;
  logic        dz;
  logic [7:0]  lat_sel;
  logic        unused_status;

  assign unused_status = ^{dp_status_i[7:6], dp_status_i[0]};

  always_comb begin
    lat_sel = L_SHORT;
    case (op_i)
      OP_ADD, OP_SUB:                         lat_sel = L_ADD;
      OP_MUL:                                 lat_sel = L_MUL;
      OP_MADD, OP_MSUB, OP_NMADD, OP_NMSUB:   lat_sel = L_MAC;
      OP_FLOAT2INT, OP_FLOAT2INT_U,
      OP_INT2FLOAT, OP_INT2FLOAT_U:           lat_sel = L_CVT;
      OP_DIV, OP_SQRT:                        lat_sel = L_DIVSQRT;
      default:                                lat_sel = L_SHORT;
    endcase
  end

  // Rounding modes 5 and 6 are reserved; 7 can only appear if frm itself is dynamic.
  assign rm_res   = (rm_i == 3'b111) ? frm_i : rm_i;
  assign rm_bad   = (rm_res >= 3'd5);
  assign cnt_zero = (cnt_q == 8'd0);

  assign req_ready_o = (state_q == IDLE) || ((state_q == BUSY) && cnt_zero);
  assign take        = req_valid_i && req_ready_o && !flush_i;
  assign accept      = take && !rm_bad;
  assign illegal_d   = take && rm_bad;
  assign wb          = (state_q == BUSY) && cnt_zero && !flush_i;

  always_comb begin
    dest_int = 1'b0;
    case (dp_op_o)
      OP_FLOAT2INT, OP_FLOAT2INT_U, OP_MOVE_F2I,
      OP_CMP_EQ, OP_CMP_LT, OP_CMP_LE, OP_FCLASS: dest_int = 1'b1;
      default:                                   dest_int = 1'b0;
    endcase
  end

  assign dest_fp = !dest_int && (dp_op_o != OP_NOP) && (dp_op_o <= OP_INT2FLOAT_U);

  always_comb begin
    flag_op = 1'b1;
    case (dp_op_o)
      OP_NOP, OP_SGNJ, OP_SGNJN, OP_SGNJX,
      OP_MOVE_F2I, OP_MOVE_I2F, OP_FCLASS: flag_op = 1'b0;
      default:                             flag_op = (dp_op_o <= OP_INT2FLOAT_U);
    endcase
  end

  // Divide-by-zero only for a finite, non-zero dividend over a (signed) zero divisor.
  assign dz = (dp_op_o == OP_DIV) && dp_status_i[1] && (dp_rs2_o[30:0] == 31'd0) &&
              (dp_rs1_o[30:23] != 8'hFF) && (dp_rs1_o[30:0] != 31'd0);

  always_comb begin
    fflags_d = fflags_o;
    if (fflags_clr_i) begin
      fflags_d = 5'd0;
    end else if (wb && flag_op) begin
      fflags_d = fflags_o | {dp_status_i[2], dz, dp_status_i[4],
                             dp_status_i[3] & dp_status_i[5], dp_status_i[5]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = lat_sel - 8'd1;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_zero) begin
          if (accept) begin
            state_d = BUSY;
            cnt_d   = lat_sel - 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      dp_op_o      <= OP_NOP;
      dp_rnd_o     <= 3'd0;
      dp_rs1_o     <= 32'd0;
      dp_rs2_o     <= 32'd0;
      dp_rs3_o     <= 32'd0;
      dp_rs1_int_o <= 32'd0;
      rd_q         <= 5'd0;
      illegal_rm_o <= 1'b0;
      fflags_o     <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      illegal_rm_o <= illegal_d;
      fflags_o     <= fflags_d;
      if (accept) begin
        dp_op_o      <= op_i;
        dp_rnd_o     <= rm_res;
        dp_rs1_o     <= rs1_i;
        dp_rs2_o     <= rs2_i;
        dp_rs3_o     <= rs3_i;
        dp_rs1_int_o <= rs1_int_i;
        rd_q         <= rd_addr_i;
      end
    end
  end

  assign fp_we_o     = wb && dest_fp;
  assign fp_waddr_o  = fp_we_o ? rd_q : 5'd0;
  assign fp_wdata_o  = fp_we_o ? dp_result_i : 32'd0;
  assign int_we_o    = wb && dest_int;
  assign int_waddr_o = int_we_o ? rd_q : 5'd0;
  assign int_wdata_o = int_we_o ? dp_result_i : 32'd0;

endmodule

// File: tb/tb_ibex_fpu_issue_seq.sv
// tb/tb_ibex_fpu_issue_seq.sv - directed bench for ibex_fpu_issue_seq; inputs change at posedge+1,
// outputs are sampled at the following negedge.
module tb_ibex_fpu_issue_seq;

  localparam logic [4:0] OP_NOP    = 5'd0;
  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_MUL    = 5'd3;
  localparam logic [4:0] OP_DIV    = 5'd4;
  localparam logic [4:0] OP_MADD   = 5'd6;
  localparam logic [4:0] OP_CMP_LT = 5'd16;
  localparam logic [4:0] OP_FCLASS = 5'd18;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  op;
  logic [2:0]  rm, frm;
  logic [31:0] rs1, rs2, rs3, rs1_int;
  logic [4:0]  rd_addr;
  logic        flush;
  logic [4:0]  dp_op;
  logic [2:0]  dp_rnd;
  logic [31:0] dp_rs1, dp_rs2, dp_rs3, dp_rs1_int;
  logic [31:0] dp_result;
  logic [7:0]  dp_status;
  logic        fp_we, int_we, illegal_rm, fflags_clr;
  logic [4:0]  fp_waddr, int_waddr, fflags;
  logic [31:0] fp_wdata, int_wdata;

  int vectors = 0;
  int miscompares = 0;

  ibex_fpu_issue_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .rm_i(rm), .frm_i(frm),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .rs1_int_i(rs1_int),
    .rd_addr_i(rd_addr), .flush_i(flush),
    .dp_op_o(dp_op), .dp_rnd_o(dp_rnd),
    .dp_rs1_o(dp_rs1), .dp_rs2_o(dp_rs2), .dp_rs3_o(dp_rs3), .dp_rs1_int_o(dp_rs1_int),
    .dp_result_i(dp_result), .dp_status_i(dp_status),
    .fp_we_o(fp_we), .fp_waddr_o(fp_waddr), .fp_wdata_o(fp_wdata),
    .int_we_o(int_we), .int_waddr_o(int_waddr), .int_wdata_o(int_wdata),
    .illegal_rm_o(illegal_rm), .fflags_o(fflags), .fflags_clr_i(fflags_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; op = OP_NOP; rm = 3'd0; frm = 3'd0;
    rs1 = '0; rs2 = '0; rs3 = '0; rs1_int = '0; rd_addr = '0; flush = 1'b0;
    dp_result = '0; dp_status = '0; fflags_clr = 1'b0;

    #3;
    chk("rst_ready", req_ready, 1);
    chk("rst_dp_op", dp_op, OP_NOP);
    chk("rst_dp_rs1", dp_rs1, 0);
    chk("rst_fp_we", fp_we, 0);
    chk("rst_int_we", int_we, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_illegal", illegal_rm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD: write at T+2
    go(); req_valid = 1; op = OP_ADD; rm = 3'b000; rs1 = 32'h3F800000; rs2 = 32'h40000000; rd_addr = 5'd5;
    mid(); chk("add_ready_T", req_ready, 1);
    go(); req_valid = 0; dp_result = 32'h40400000;
    mid(); chk("add_we_T1", fp_we, 0); chk("add_ready_T1", req_ready, 0);
    chk("add_dp_op", dp_op, OP_ADD); chk("add_dp_rs1", dp_rs1, 32'h3F800000);
    chk("add_dp_rs2", dp_rs2, 32'h40000000); chk("add_dp_rnd", dp_rnd, 0);
    go();
    mid(); chk("add_we_T2", fp_we, 1); chk("add_waddr", fp_waddr, 5); chk("add_wdata", fp_wdata, 32'h40400000);
    chk("add_int_we", int_we, 0); chk("add_ready_T2", req_ready, 1);
    go();
    mid(); chk("add_we_T3", fp_we, 0); chk("add_fflags", fflags, 0);

    // DIV by zero: ready low T+1..T+11, write at T+12, DZ set
    go(); req_valid = 1; op = OP_DIV; rm = 3'b001; rs1 = 32'h3F800000; rs2 = 32'h0; rd_addr = 5'd7;
    dp_status = 8'h02; dp_result = 32'h7F800000;
    mid();
    for (int i = 1; i <= 11; i++) begin
      go(); req_valid = 0;
      mid(); chk($sformatf("div_ready_T%0d", i), req_ready, 0); chk($sformatf("div_we_T%0d", i), fp_we, 0);
    end
    chk("div_dp_rnd", dp_rnd, 1);
    go();
    mid(); chk("div_we_T12", fp_we, 1); chk("div_waddr", fp_waddr, 7); chk("div_ready_T12", req_ready, 1);
    go(); dp_status = 8'h00;
    mid(); chk("div_fflags", fflags, 5'b01000); chk("div_we_T13", fp_we, 0);

    // CMP_LT (dynamic rm) then FCLASS back-to-back
    go(); req_valid = 1; op = OP_CMP_LT; rm = 3'b111; frm = 3'b010; rd_addr = 5'd3; dp_result = 32'h1;
    mid(); chk("cmp_ready", req_ready, 1);
    go(); op = OP_FCLASS; rm = 3'b000; rd_addr = 5'd4;
    mid(); chk("cmp_int_we", int_we, 1); chk("cmp_int_waddr", int_waddr, 3); chk("cmp_int_wdata", int_wdata, 1);
    chk("cmp_fp_we", fp_we, 0); chk("cmp_dp_rnd", dp_rnd, 2); chk("cmp_ready_wb", req_ready, 1);
    go(); req_valid = 0;
    mid(); chk("fcls_int_we", int_we, 1); chk("fcls_int_waddr", int_waddr, 4); chk("fcls_fp_we", fp_we, 0);
    chk("fcls_dp_op", dp_op, OP_FCLASS); chk("fcls_dp_rnd", dp_rnd, 0);
    go();
    mid(); chk("fcls_after_we", int_we, 0); chk("fcls_after_ready", req_ready, 1); chk("cmp_fflags", fflags, 5'b01000);

    // NOP writes nothing
    go(); req_valid = 1; op = OP_NOP;
    mid();
    go(); req_valid = 0;
    mid(); chk("nop_fp_we", fp_we, 0); chk("nop_int_we", int_we, 0); chk("nop_ready", req_ready, 1);

    // clear fflags
    go(); fflags_clr = 1;
    mid();
    go(); fflags_clr = 0;
    mid(); chk("clr_fflags", fflags, 0);

    // illegal rounding mode via dynamic frm=101
    go(); req_valid = 1; op = OP_ADD; rm = 3'b111; frm = 3'b101; rd_addr = 5'd6;
    mid(); chk("ill_pulse_T", illegal_rm, 0);
    go(); req_valid = 0; frm = 3'b000;
    mid(); chk("ill_pulse_T1", illegal_rm, 1); chk("ill_fp_we_T1", fp_we, 0);
    chk("ill_ready_T1", req_ready, 1); chk("ill_dp_op", dp_op, OP_NOP);
    go();
    mid(); chk("ill_pulse_T2", illegal_rm, 0); chk("ill_fp_we_T2", fp_we, 0);

    // MUL flushed at T+1
    go(); req_valid = 1; op = OP_MUL; rm = 3'b000; rd_addr = 5'd9; dp_status = 8'h3F;
    mid();
    go(); req_valid = 0; flush = 1;
    mid(); chk("flush_we_T1", fp_we, 0); chk("flush_ready_T1", req_ready, 0);
    go(); flush = 0;
    mid(); chk("flush_ready_T2", req_ready, 1); chk("flush_we_T2", fp_we, 0);
    go();
    mid(); chk("flush_we_T3", fp_we, 0); chk("flush_fflags", fflags, 0);

    // MADD inexact with clear on writeback cycle, then an inexact ADD
    go(); req_valid = 1; op = OP_MADD; rd_addr = 5'd10; dp_status = 8'h20;
    mid();
    go(); req_valid = 0;
    mid();
    go(); mid();
    go(); mid(); chk("madd_we_T3", fp_we, 0);
    go(); fflags_clr = 1;
    mid(); chk("madd_we_T4", fp_we, 1); chk("madd_waddr", fp_waddr, 10);
    go(); fflags_clr = 0;
    mid(); chk("madd_clr_wins", fflags, 0);
    go(); req_valid = 1; op = OP_ADD; rd_addr = 5'd11;
    mid();
    go(); req_valid = 0;
    mid();
    go();
    mid(); chk("nx_we", fp_we, 1);
    go();
    mid(); chk("nx_fflags", fflags, 5'b00001);

    // async reset mid-DIV
    go(); req_valid = 1; op = OP_DIV; rd_addr = 5'd12; dp_status = 8'h04;
    mid();
    go(); req_valid = 0;
    mid(); chk("ar_busy", req_ready, 0);
    go(); #2; rst_n = 0; #1;
    chk("ar_ready", req_ready, 1); chk("ar_dp_op", dp_op, OP_NOP);
    chk("ar_fflags", fflags, 0); chk("ar_dp_rs1", dp_rs1, 0);
    mid(); rst_n = 1;
    for (int i = 0; i < 14; i++) begin
      go();
      mid(); chk($sformatf("ar_no_wb_%0d", i), fp_we, 0);
    end
    chk("ar_fflags_end", fflags, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
